// File: rtl/cam_writer.sv
`default_nettype none
// ============================================================================
//  Module      : cam_writer
//  Description : Write side of a small content-addressable store. Holds DEPTH
//                entries of DATA_WIDTH bits, each with a valid bit. Writes go
//                either to an explicit index or to the lowest free entry.
//                Single entries can be invalidated. A clear request starts a
//                sweep that zeroes one entry per cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   clock, rising edge
//    rst_n               in   asynchronous active-low reset
//    write_valid_i       in   write request
//    write_ready_o       out  write can be accepted (IDLE only)
//    write_alloc_i       in   1: lowest free entry, 0: write_index_i
//    write_index_i       in   explicit write index
//    write_data_i        in   write data
//    invalidate_i        in   clear valid bit of invalidate_index_i
//    invalidate_index_i  in   index to invalidate
//    clear_i             in   start full-array clear sweep
//    all_data_o          out  flattened storage, entry k at [k*DW +: DW]
//    read_valid_o        out  per-entry valid bits
//    write_done_o        out  one-cycle pulse, write committed
//    write_err_o         out  one-cycle pulse, write rejected
//    write_index_o       out  index of the last done/rejected write
//    full_o              out  every entry valid
//    count_o             out  number of valid entries
// ============================================================================
module cam_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_valid_i,
  output logic                        write_ready_o,
  input  logic                        write_alloc_i,
  input  logic [ADDR_WIDTH-1:0]       write_index_i,
  input  logic [DATA_WIDTH-1:0]       write_data_i,
  input  logic                        invalidate_i,
  input  logic [ADDR_WIDTH-1:0]       invalidate_index_i,
  input  logic                        clear_i,
  output logic [DATA_WIDTH*DEPTH-1:0] all_data_o,
  output logic [DEPTH-1:0]            read_valid_o,
  output logic                        write_done_o,
  output logic                        write_err_o,
  output logic [ADDR_WIDTH-1:0]       write_index_o,
  output logic                        full_o,
  output logic [ADDR_WIDTH:0]         count_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  // DEPTH widened by one bit so indices up to 2**ADDR_WIDTH-1 compare cleanly
  localparam logic [ADDR_WIDTH:0]   c_DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(DEPTH-1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_widx;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  w_idle;
  logic                  w_free_found;
  logic [ADDR_WIDTH-1:0] w_free_idx;
  logic                  w_idx_in_range;
  logic                  w_inv_in_range;
  logic                  w_wr_req;
  logic                  w_wr_ok;
  logic                  w_commit;
  logic                  w_reject;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_err_idx;
  logic                  w_inv_en;
  logic [ADDR_WIDTH:0]   w_count;

  assign w_idle = (r_state == S_IDLE);

  // Lowest free entry: scan from the top so the lowest hit is the last write.
  // Index stays 0 when nothing is free, which is also the index reported on
  // an alloc rejection.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!r_valid[k]) begin
        w_free_found = 1'b1;
        w_free_idx   = ADDR_WIDTH'(k);
      end
    end
  end

  assign w_idx_in_range = ({1'b0, write_index_i}      < c_DEPTH_W);
  assign w_inv_in_range = ({1'b0, invalidate_index_i} < c_DEPTH_W);

  // A clear on the same edge as a write swallows the write silently.
  assign w_wr_req  = write_valid_i && w_idle && !clear_i;
  assign w_wr_ok   = write_alloc_i ? w_free_found : w_idx_in_range;
  assign w_commit  = w_wr_req && w_wr_ok;
  assign w_reject  = w_wr_req && !w_wr_ok;
  assign w_wr_idx  = write_alloc_i ? w_free_idx : write_index_i;
  assign w_err_idx = write_alloc_i ? '0 : write_index_i;

  assign w_inv_en  = invalidate_i && w_inv_in_range && w_idle && !clear_i;

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + (ADDR_WIDTH+1)'(r_valid[k]);
    end
  end

  // --------------------------------------------------------------------------
  // Control: state, sweep counter, response pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sweep <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_widx  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_i) begin
            r_state <= S_CLEAR;
            r_sweep <= '0;
          end else if (w_commit) begin
            r_done <= 1'b1;
            r_widx <= w_wr_idx;
          end else if (w_reject) begin
            r_err  <= 1'b1;
            r_widx <= w_err_idx;
          end
        end
        S_CLEAR: begin
          if (r_sweep == c_LAST) begin
            r_state <= S_IDLE;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sweep <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage: data and valid bits
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_sweep == ADDR_WIDTH'(k)) begin
          r_data[k]  <= '0;
          r_valid[k] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        // Invalidate first so a write to the same entry overrides it.
        if (w_inv_en && (invalidate_index_i == ADDR_WIDTH'(k))) begin
          r_valid[k] <= 1'b0;
        end
        if (w_commit && (w_wr_idx == ADDR_WIDTH'(k))) begin
          r_data[k]  <= write_data_i;
          r_valid[k] <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign all_data_o[g*DATA_WIDTH +: DATA_WIDTH] = r_data[g];
  end

  assign read_valid_o  = r_valid;
  assign write_ready_o = w_idle;
  assign write_done_o  = r_done;
  assign write_err_o   = r_err;
  assign write_index_o = r_widx;
  assign full_o        = &r_valid;
  assign count_o       = w_count;

endmodule
`default_nettype wire
